// File: rtl/fir_acc_pkg.sv
// rtl/fir_acc_pkg.sv - shared width, FSM states, clamp limits and overflow helper for the FIR tap accumulator
package fir_acc_pkg;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DW-1:0] SAT_NEG = 16'h8000;

    function automatic logic sat_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] s);
        return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    endfunction
endpackage

// File: rtl/fir_tap_accumulator_if.sv
// rtl/fir_tap_accumulator_if.sv - product stream in, accumulated sample stream out, plus status
interface fir_tap_accumulator_if;
    import fir_acc_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ovf;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, ovf, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, ovf, busy
    );
endinterface

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - combinational accumulate step: PPA add, signed overflow detect, optional clamp (FIR_ACC_SAT_EN)
module acc_sat_add
    import fir_acc_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          ovf
);
    logic [DW-1:0] raw;
    logic          c_out_unused;

    ppa u_ppa (
        .a     (a),
        .b     (b),
        .c_in  (1'b0),
        .sum   (raw),
        .c_out (c_out_unused)
    );

    assign ovf = sat_ovf(a, b, raw);

`ifdef FIR_ACC_SAT_EN
    // overflow only happens with like-signed operands, so a's sign picks the rail
    assign sum = ovf ? (a[DW-1] ? SAT_NEG : SAT_POS) : raw;
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/ppa.sv
// rtl/ppa.sv - 16-bit Brent-Kung parallel prefix adder
module ppa (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] gg;
    logic [15:0] pp;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gg = g;
        pp = p;
        gg[0] = g[0] | (p[0] & c_in);
        // up-sweep: spans of 2,4,8,16 land on bits 1,3,7,15
        for (int l = 0; l < 4; l++) begin
            for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        // down-sweep fills the remaining prefixes
        for (int l = 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < 16; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        sum[0] = p[0] ^ c_in;
        for (int i = 1; i < 16; i++) begin
            sum[i] = p[i] ^ gg[i-1];
        end
        c_out = gg[15];
    end
endmodule

// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums TAPS signed products per output sample; FIR_ACC_SAT_EN selects clamp instead of wrap
module fir_tap_accumulator
    import fir_acc_pkg::*;
#(
    parameter int            TAPS     = 8,
    parameter logic [DW-1:0] INIT_VAL = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_tap_accumulator_if.slave bus
);
    localparam int CW = $clog2(TAPS + 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] acc;
    logic [CW-1:0] tap_cnt;
    logic [DW-1:0] out_data_r;
    logic          out_valid_r;
    logic          ovf_r;
    logic [DW-1:0] add_sum;
    logic          add_ovf;
    logic          accept;
    logic          last;
    logic          in_ready_c;
    logic          busy_c;

    acc_sat_add u_add (
        .a   (acc),
        .b   (bus.in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign accept = bus.in_valid && in_ready_c;
    assign last   = (tap_cnt == CW'(TAPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (accept) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (accept && last) state_nxt = HOLD;
            end
            HOLD: begin
                busy_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= INIT_VAL;
            tap_cnt     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= add_sum;
                        tap_cnt <= CW'(1);
                        ovf_r   <= add_ovf;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc     <= add_sum;
                        tap_cnt <= tap_cnt + CW'(1);
                        ovf_r   <= ovf_r | add_ovf;
                        if (last) begin
                            out_data_r  <= add_sum;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // ovf stays up here; the next sample's first accept replaces it
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        acc         <= INIT_VAL;
                        tap_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb/tb_fir_tap_accumulator.sv - scoreboard bench over three accumulator configurations
module tb_fir_tap_accumulator;
    logic clk;
    logic rst;

    logic [2:0]  iv;
    logic [15:0] id [3];
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [15:0] od [3];
    logic [2:0]  of;
    logic [2:0]  bz;

    int n_chk;
    int n_fail;
    logic [16:0] sb[$];
    logic [15:0] tv[4];
    int          tg[4];

    fir_tap_accumulator_if if0 ();
    fir_tap_accumulator_if if1 ();
    fir_tap_accumulator_if if2 ();

    fir_tap_accumulator #(.TAPS(4), .INIT_VAL(16'h0000)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    fir_tap_accumulator #(.TAPS(2), .INIT_VAL(16'h0000)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    fir_tap_accumulator #(.TAPS(4), .INIT_VAL(16'h0002)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.in_valid = iv[0];   assign if0.in_data = id[0];   assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];   assign if1.in_data = id[1];   assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2];   assign if2.in_data = id[2];   assign if2.out_ready = ordy[2];
    assign ir = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign of = {if2.ovf, if1.ovf, if0.ovf};
    assign bz = {if2.busy, if1.busy, if0.busy};
    assign od[0] = if0.out_data;
    assign od[1] = if1.out_data;
    assign od[2] = if2.out_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mstep(input logic [15:0] a, input logic [15:0] b);
        int s;
        logic [15:0] r;
        logic o;
        s = int'($signed(a)) + int'($signed(b));
        o = (s > 32767) || (s < -32768);
        r = s[15:0];
`ifdef FIR_ACC_SAT_EN
        if (s > 32767) r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
`endif
        return {o, r};
    endfunction

    task automatic put(input int d, input logic [15:0] x, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        iv[d] = 1'b1;
        id[d] = x;
        t = 0;
        while (!ir[d] && t < 20) begin @(posedge clk); #1; t++; end
        if (!ir[d]) chk("in_ready_timeout", ir[d], 1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        id[d] = 16'hDEAD;
    endtask

    task automatic run_sample(input int d, input logic [15:0] init, input int n);
        logic [15:0] acc;
        logic        ovs;
        logic [16:0] r;
        acc = init;
        ovs = 1'b0;
        for (int i = 0; i < n; i++) begin
            put(d, tv[i], tg[i]);
            r   = mstep(acc, tv[i]);
            acc = r[15:0];
            ovs = (i == 0) ? r[16] : (ovs | r[16]);
            if (i < n - 1) begin
                chk("accum_ovf", of[d], ovs);
                chk("accum_busy", bz[d], 1);
                chk("no_early_valid", ov[d], 0);
            end
        end
        sb.push_back({ovs, acc});
    endtask

    task automatic collect(input int d, input int hold);
        logic [16:0] e;
        chk("out_valid_latency", ov[d], 1);
        chk("sb_depth", sb.size(), 1);
        e = (sb.size() != 0) ? sb.pop_front() : 17'h0;
        chk("out_data", od[d], e[15:0]);
        chk("out_ovf", of[d], e[16]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", ov[d], 1);
            chk("hold_in_ready", ir[d], 0);
            chk("hold_data", od[d], e[15:0]);
            chk("hold_ovf", of[d], e[16]);
            chk("hold_busy", bz[d], 1);
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk("exit_valid", ov[d], 0);
        chk("exit_in_ready", ir[d], 1);
        chk("exit_busy", bz[d], 0);
        chk("exit_ovf_sticky", of[d], e[16]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        iv     = '0;
        ordy   = '0;
        for (int i = 0; i < 3; i++) id[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data0", od[0], 0);
        chk("rst_ovf", of, 0);
        chk("rst_busy", bz, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", ir, 3'b111);

        tv[0] = 16'd1; tv[1] = 16'd2; tv[2] = 16'd3; tv[3] = 16'd4;
        tg[0] = 0; tg[1] = 0; tg[2] = 0; tg[3] = 0;
        run_sample(0, 16'h0000, 4);
        collect(0, 5);

        tv[0] = 16'h7000; tv[1] = 16'h2000;
        run_sample(1, 16'h0000, 2);
        collect(1, 1);

        tv[0] = 16'h8000; tv[1] = 16'hFFFF;
        run_sample(1, 16'h0000, 2);
        collect(1, 0);

        tv[0] = 16'd5; tv[1] = 16'd5; tv[2] = 16'd5; tv[3] = 16'd5;
        tg[0] = 0; tg[1] = 2; tg[2] = 0; tg[3] = 1;
        run_sample(2, 16'h0002, 4);
        collect(2, 2);

        tv[0] = 16'hFFFE; tv[1] = 16'h0003;
        tg[0] = 3; tg[1] = 0;
        run_sample(1, 16'h0000, 2);
        collect(1, 0);

        put(0, 16'h0100, 0);
        put(0, 16'h0200, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", ov[0], 0);
        chk("midrst_data", od[0], 0);
        chk("midrst_ovf", of[0], 0);
        chk("midrst_busy", bz[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", ir[0], 1);
        tv[0] = 16'd1; tv[1] = 16'd1; tv[2] = 16'd1; tv[3] = 16'd1;
        tg[0] = 0; tg[1] = 0; tg[2] = 0; tg[3] = 0;
        run_sample(0, 16'h0000, 4);
        collect(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
